// File: rtl/keycode_action_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : keycode_action_ctrl
// Description : Decodes the two USB HID keycodes written by software into the
//               keycode PIO word and produces per-action held levels, one-cycle
//               press/release pulses, frame-paced auto-repeat events,
//               last-input-priority axis directions and a pause toggle.
// Ports       : clk          system clock
//               reset_n      asynchronous active-low reset, synchronous release
//               keycode      {key1, key0} from the PIO out_port
//               frame_tick   one-cycle pulse per video frame
//               held         action currently held (bit i = action i)
//               press        one-cycle pulse on a held rising edge
//               release_evt  one-cycle pulse on a held falling edge
//                            ("release" is a reserved word in SystemVerilog)
//               repeat_evt   actions 0..4: pulse on press and on each repeat
//               move_x       00 none, 01 right, 10 left
//               move_y       00 none, 01 down, 10 up
//               paused       pause toggle state
// Actions     : 0 up, 1 left, 2 down, 3 right, 4 fire, 5 pause
// Revision    : 1.0 - initial release
// ============================================================================
module keycode_action_ctrl #(
    parameter logic [7:0]  KC_UP         = 8'h1A,
    parameter logic [7:0]  KC_LEFT       = 8'h04,
    parameter logic [7:0]  KC_DOWN       = 8'h16,
    parameter logic [7:0]  KC_RIGHT      = 8'h07,
    parameter logic [7:0]  KC_FIRE       = 8'h2C,
    parameter logic [7:0]  KC_PAUSE      = 8'h13,
    parameter int unsigned DELAY_FRAMES  = 15,
    parameter int unsigned REPEAT_FRAMES = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] keycode,
    input  logic        frame_tick,
    output logic [5:0]  held,
    output logic [5:0]  press,
    output logic [5:0]  release_evt,
    output logic [4:0]  repeat_evt,
    output logic [1:0]  move_x,
    output logic [1:0]  move_y,
    output logic        paused
);

    localparam logic [47:0] c_codes      = {KC_PAUSE, KC_FIRE, KC_RIGHT, KC_DOWN, KC_LEFT, KC_UP};
    localparam logic [7:0]  c_delay_last = 8'(DELAY_FRAMES - 1);
    localparam logic [7:0]  c_rep_last   = 8'(REPEAT_FRAMES - 1);

    localparam logic [1:0]  S_IDLE   = 2'd0;
    localparam logic [1:0]  S_DELAY  = 2'd1;
    localparam logic [1:0]  S_REPEAT = 2'd2;

    logic [5:0] w_hit;
    logic [5:0] w_press_nxt;
    logic [5:0] w_rel_nxt;
    logic [4:0] w_emit;
    logic [1:0] w_last_x_nxt;
    logic [1:0] w_last_y_nxt;
    logic [1:0] w_move_x_nxt;
    logic [1:0] w_move_y_nxt;

    logic [5:0] r_held;
    logic [5:0] r_press;
    logic [5:0] r_release;
    logic [4:0] r_repeat;
    logic [1:0] r_move_x;
    logic [1:0] r_move_y;
    logic [1:0] r_last_x;
    logic [1:0] r_last_y;
    logic       r_paused;

    // ------------------------------------------------------------------
    // Decode: a code present in both bytes still yields a single hit.
    // A zero byte means "no key" and never matches.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_dec
            assign w_hit[gi] = (c_codes[8*gi +: 8] != 8'h00) &&
                               ((keycode[7:0]  == c_codes[8*gi +: 8]) ||
                                (keycode[15:8] == c_codes[8*gi +: 8]));
        end
    endgenerate

    assign w_press_nxt = w_hit & ~r_held;
    assign w_rel_nxt   = ~w_hit & r_held;

    // ------------------------------------------------------------------
    // Axis resolution. "last" remembers which direction was pressed most
    // recently (01 positive, 10 negative); a simultaneous press of both
    // clears it so the axis reads 00 until one of them is released.
    // ------------------------------------------------------------------
    function automatic logic [1:0] f_last(input logic [1:0] last,
                                          input logic       p_pos,
                                          input logic       p_neg);
        logic [1:0] v;
        v = last;
        if (p_pos && p_neg)
            v = 2'b00;
        else if (p_pos)
            v = 2'b01;
        else if (p_neg)
            v = 2'b10;
        return v;
    endfunction

    function automatic logic [1:0] f_move(input logic [1:0] last,
                                          input logic       h_pos,
                                          input logic       h_neg);
        logic [1:0] v;
        case ({h_neg, h_pos})
            2'b01:   v = 2'b01;
            2'b10:   v = 2'b10;
            2'b11:   v = last;
            default: v = 2'b00;
        endcase
        return v;
    endfunction

    always_comb begin
        w_last_x_nxt = f_last(r_last_x, w_press_nxt[3], w_press_nxt[1]);
        w_last_y_nxt = f_last(r_last_y, w_press_nxt[2], w_press_nxt[0]);
        w_move_x_nxt = f_move(w_last_x_nxt, w_hit[3], w_hit[1]);
        w_move_y_nxt = f_move(w_last_y_nxt, w_hit[2], w_hit[0]);
    end

    // ------------------------------------------------------------------
    // Auto-repeat: one three-state FSM per action 0..4.
    // ------------------------------------------------------------------
    generate
        for (genvar ga = 0; ga < 5; ga++) begin : g_rep
            logic [1:0] r_state;
            logic [1:0] w_state_nxt;
            logic [7:0] r_cnt;
            logic [7:0] w_cnt_nxt;
            logic       w_emit_bit;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_state <= S_IDLE;
                    r_cnt   <= 8'd0;
                end else begin
                    r_state <= w_state_nxt;
                    r_cnt   <= w_cnt_nxt;
                end
            end

            // Release takes priority over everything; a press ignores a
            // coincident frame_tick because the counter restarts at 0.
            always_comb begin
                w_state_nxt = r_state;
                w_cnt_nxt   = r_cnt;
                if (!w_hit[ga]) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 8'd0;
                end else begin
                    case (r_state)
                        S_IDLE: begin
                            if (!r_held[ga]) begin
                                w_state_nxt = S_DELAY;
                                w_cnt_nxt   = 8'd0;
                            end
                        end
                        S_DELAY: begin
                            if (frame_tick) begin
                                if (r_cnt == c_delay_last) begin
                                    w_state_nxt = S_REPEAT;
                                    w_cnt_nxt   = 8'd0;
                                end else begin
                                    w_cnt_nxt = r_cnt + 8'd1;
                                end
                            end
                        end
                        S_REPEAT: begin
                            if (frame_tick) begin
                                if (r_cnt == c_rep_last)
                                    w_cnt_nxt = 8'd0;
                                else
                                    w_cnt_nxt = r_cnt + 8'd1;
                            end
                        end
                        default: begin
                            w_state_nxt = S_IDLE;
                            w_cnt_nxt   = 8'd0;
                        end
                    endcase
                end
            end

            always_comb begin
                w_emit_bit = 1'b0;
                if (w_hit[ga]) begin
                    case (r_state)
                        S_IDLE:   w_emit_bit = ~r_held[ga];
                        S_DELAY:  w_emit_bit = frame_tick && (r_cnt == c_delay_last);
                        S_REPEAT: w_emit_bit = frame_tick && (r_cnt == c_rep_last);
                        default:  w_emit_bit = 1'b0;
                    endcase
                end
            end

            assign w_emit[ga] = w_emit_bit;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output registers: every output is aligned with held.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_held    <= 6'd0;
            r_press   <= 6'd0;
            r_release <= 6'd0;
            r_repeat  <= 5'd0;
            r_move_x  <= 2'b00;
            r_move_y  <= 2'b00;
            r_last_x  <= 2'b00;
            r_last_y  <= 2'b00;
            r_paused  <= 1'b0;
        end else begin
            r_held    <= w_hit;
            r_press   <= w_press_nxt;
            r_release <= w_rel_nxt;
            r_repeat  <= w_emit;
            r_move_x  <= w_move_x_nxt;
            r_move_y  <= w_move_y_nxt;
            r_last_x  <= w_last_x_nxt;
            r_last_y  <= w_last_y_nxt;
            r_paused  <= r_paused ^ w_press_nxt[5];
        end
    end

    assign held        = r_held;
    assign press       = r_press;
    assign release_evt = r_release;
    assign repeat_evt  = r_repeat;
    assign move_x      = r_move_x;
    assign move_y      = r_move_y;
    assign paused      = r_paused;

endmodule
`default_nettype wire

// File: tb/tb_keycode_action_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_keycode_action_ctrl
// Description : Self-checking bench for keycode_action_ctrl. Two instances
//               share the stimulus: one with DELAY=3/REPEAT=2, one with
//               DELAY=1/REPEAT=1. Expected values come from a behavioural
//               model based on press timestamps and frames-since-press.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keycode_action_ctrl;

    localparam int c_dly [2] = '{3, 1};
    localparam int c_rpt [2] = '{2, 1};

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] keycode;
    logic        frame_tick;

    logic [5:0] held_a, press_a, rel_a;
    logic [4:0] rep_a;
    logic [1:0] mx_a, my_a;
    logic       paused_a;
    logic [5:0] held_b, press_b, rel_b;
    logic [4:0] rep_b;
    logic [1:0] mx_b, my_b;
    logic       paused_b;

    always #5 clk = ~clk;

    keycode_action_ctrl #(.DELAY_FRAMES(3), .REPEAT_FRAMES(2)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .keycode(keycode), .frame_tick(frame_tick),
        .held(held_a), .press(press_a), .release_evt(rel_a), .repeat_evt(rep_a),
        .move_x(mx_a), .move_y(my_a), .paused(paused_a)
    );

    keycode_action_ctrl #(.DELAY_FRAMES(1), .REPEAT_FRAMES(1)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .keycode(keycode), .frame_tick(frame_tick),
        .held(held_b), .press(press_b), .release_evt(rel_b), .repeat_evt(rep_b),
        .move_x(mx_b), .move_y(my_b), .paused(paused_b)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [7:0] kc_tab [6] = '{8'h1A, 8'h04, 8'h16, 8'h07, 8'h2C, 8'h13};
    logic [5:0] m_held, m_press, m_rel;
    logic [4:0] m_rep [2];
    logic [1:0] m_mx, m_my;
    logic       m_paused;
    int         m_n [2][5];     // frame ticks seen since the press
    longint     m_tp [4];       // cycle of last press, directions 0..3
    longint     cyc = 0;

    function automatic logic [1:0] axis(input bit hp, input bit hn, input longint tp, input longint tn);
        if (hp && hn) return (tp > tn) ? 2'b01 : (tn > tp) ? 2'b10 : 2'b00;
        if (hp) return 2'b01;
        if (hn) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_held = '0; m_press = '0; m_rel = '0; m_mx = '0; m_my = '0; m_paused = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_rep[k] = '0;
            for (int a = 0; a < 5; a++) m_n[k][a] = 0;
        end
        for (int d = 0; d < 4; d++) m_tp[d] = 0;
    endtask

    task automatic model_step(input logic [15:0] kc, input bit tick);
        logic [5:0] h;
        for (int i = 0; i < 6; i++)
            h[i] = (kc[7:0] == kc_tab[i]) || (kc[15:8] == kc_tab[i]);
        m_press = h & ~m_held;
        m_rel   = ~h & m_held;
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 5; a++) begin
                if (m_press[a]) begin
                    m_n[k][a]   = 0;
                    m_rep[k][a] = 1'b1;
                end else if (h[a] && tick) begin
                    m_n[k][a]++;
                    m_rep[k][a] = (m_n[k][a] == c_dly[k]) ||
                                  (m_n[k][a] > c_dly[k] && ((m_n[k][a] - c_dly[k]) % c_rpt[k]) == 0);
                end else begin
                    m_rep[k][a] = 1'b0;
                end
            end
        end
        for (int d = 0; d < 4; d++)
            if (m_press[d]) m_tp[d] = cyc;
        m_mx = axis(h[3], h[1], m_tp[3], m_tp[1]);
        m_my = axis(h[2], h[0], m_tp[2], m_tp[0]);
        if (m_press[5]) m_paused = ~m_paused;
        m_held = h;
        cyc++;
    endtask

    task automatic compare_all();
        check("held_a", held_a, m_held);     check("held_b", held_b, m_held);
        check("press_a", press_a, m_press);  check("press_b", press_b, m_press);
        check("rel_a", rel_a, m_rel);        check("rel_b", rel_b, m_rel);
        check("rep_a", rep_a, m_rep[0]);     check("rep_b", rep_b, m_rep[1]);
        check("mx_a", mx_a, m_mx);           check("mx_b", mx_b, m_mx);
        check("my_a", my_a, m_my);           check("my_b", my_b, m_my);
        check("paused_a", paused_a, m_paused);
        check("paused_b", paused_b, m_paused);
    endtask

    // One clock: drive, let the DUT sample, advance the model, compare.
    task automatic step(input logic [15:0] kc, input bit tick);
        keycode    = kc;
        frame_tick = tick;
        @(posedge clk);
        model_step(kc, tick);
        #1;
        compare_all();
    endtask

    // Hold a keycode for n cycles with a frame_tick every `period` cycles.
    task automatic run(input logic [15:0] kc, input int n, input int period);
        for (int t = 1; t <= n; t++)
            step(kc, (period > 0) && (t % period == 0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] k0, k1;
        logic [7:0] pool [8];

        // Reset with a key already held
        reset_n    = 1'b0;
        keycode    = 16'h0004;
        frame_tick = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        #3 reset_n = 1'b1;
        step(16'h0004, 1'b0);
        check("rst_held", held_a, 6'b000010);
        check("rst_press", press_a, 6'b000010);
        check("rst_rep1", rep_a[1], 1'b1);
        check("rst_mx", mx_a, 2'b10);
        run(16'h0004, 5, 0);
        run(16'h0000, 3, 0);

        // Auto-repeat on fire, tick every 10 cycles, release between ticks 7 and 9
        run(16'h002C, 85, 10);
        run(16'h0000, 10, 10);

        // SOCD on X and Y
        run(16'h0007, 3, 0); run(16'h0407, 3, 0); run(16'h0400, 3, 0);
        run(16'h0700, 3, 0); run(16'h0000, 3, 0);
        run(16'h0407, 3, 0);
        check("socd_both", mx_a, 2'b00);
        run(16'h0007, 3, 0); run(16'h0000, 2, 0);
        run(16'h1A00, 2, 0); run(16'h1A16, 3, 0); run(16'h0016, 2, 0);
        run(16'h161A, 2, 0); run(16'h0000, 2, 0);

        // Pause toggle
        run(16'h1300, 50, 0);
        check("pause_on", paused_a, 1'b1);
        run(16'h0000, 5, 0);
        run(16'h1300, 10, 0);
        check("pause_off", paused_a, 1'b0);
        run(16'h0000, 3, 0);

        // Press coincident with frame_tick
        step(16'h001A, 1'b1);
        run(16'h001A, 20, 6);
        run(16'h0000, 3, 0);

        // Duplicate code in both bytes
        run(16'h1616, 3, 0);
        run(16'h0016, 3, 0);
        run(16'h0000, 3, 0);

        // Asynchronous reset in the middle of a hold
        run(16'h2C07, 6, 2);
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        #1 reset_n = 1'b1;
        run(16'h2C07, 6, 2);

        // Randomized
        pool = '{8'h00, 8'h1A, 8'h04, 8'h16, 8'h07, 8'h2C, 8'h13, 8'h55};
        k0 = 8'h00; k1 = 8'h00;
        for (int r = 0; r < 4000; r++) begin
            if ($urandom_range(7) == 0) k0 = pool[$urandom_range(7)];
            if ($urandom_range(7) == 0) k1 = pool[$urandom_range(7)];
            if ((r / 500) % 4 == 3) begin
                k0 = pool[$urandom_range(7)];
                k1 = pool[$urandom_range(7)];
            end
            step({k1, k0}, $urandom_range(3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/keycode_action_ctrl.md
Name: keycode_action_ctrl

Overview:
- Consumes the 16-bit keycode word driven by the Avalon keycode PIO. The NIOS software writes two USB HID keycodes into that word: key0 in [7:0], key1 in [15:8].
- Decodes six game actions and produces registered held levels, one-cycle press/release pulses, frame-paced auto-repeat events, resolved per-axis movement directions, and a pause toggle.
- Output feeds the game/sprite logic. Runs in the same clock domain as the PIO.

Parameters:
- KC_UP, 8'h1A, HID code for action 0 (W)
- KC_LEFT, 8'h04, HID code for action 1 (A)
- KC_DOWN, 8'h16, HID code for action 2 (S)
- KC_RIGHT, 8'h07, HID code for action 3 (D)
- KC_FIRE, 8'h2C, HID code for action 4 (space)
- KC_PAUSE, 8'h13, HID code for action 5 (P)
- DELAY_FRAMES, 15, frame_ticks from press to first auto-repeat; legal range 1..255
- REPEAT_FRAMES, 4, frame_ticks between subsequent auto-repeats; legal range 1..255

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; asynchronous, active-low
- keycode  in  16  PIO out_port; {key1, key0}
- frame_tick  in  1  one-cycle pulse per video frame (vsync-derived)
- held  out  6  action currently held; bit i = action i
- press  out  6  one-cycle pulse on held rising edge
- release  out  6  one-cycle pulse on held falling edge
- repeat_evt  out  5  actions 0..4: pulse on press and on each auto-repeat
- move_x  out  2  00 none, 01 right, 10 left
- move_y  out  2  00 none, 01 down, 10 up
- paused  out  1  pause toggle state

Behaviour:
- Reset (async assert, sync release): every output is 0, all repeat FSMs are IDLE, all counters are 0, last-axis memory is cleared.
- Decode: hit[i] = (key0==KC_i) | (key1==KC_i).
  - 8'h00 never matches; KC_* parameters must be nonzero.
  - The same code in both bytes counts once.
- Latency: held, press and release are all registered, one cycle after keycode changes.
  - held <= hit
  - press <= hit & ~held
  - release <= ~hit & held
- After reset deasserts, a key already held causes a press pulse on the first clock.
- Auto-repeat, one FSM per action 0..4, with an 8-bit frame counter cnt:
  - IDLE: on hit & ~held, emit repeat_evt (same cycle as press), cnt <= 0, go to DELAY.
  - DELAY: on frame_tick, if cnt == DELAY_FRAMES-1, emit repeat_evt, cnt <= 0, go to REPEAT; otherwise cnt++.
  - REPEAT: on frame_tick, if cnt == REPEAT_FRAMES-1, emit repeat_evt, cnt <= 0; otherwise cnt++.
  - Any state with ~hit goes to IDLE next cycle. No emit on release.
  - If press and frame_tick coincide, press wins and that tick is not counted.
  - If release and the terminal tick coincide, release wins and there is no emit.
  - With REPEAT_FRAMES=1, the FSM emits on every frame_tick while in REPEAT.
- Axis resolution (last-input priority), shown for X; Y is identical with up=10, down=01:
  - Only right held: 01. Only left held: 10. Neither held: 00.
  - Both held: the most recently pressed key wins (last_x register updated on press).
  - Both pressed in the same cycle: 00 until one is released.
  - Releasing the winner while the other is still held: the other key takes effect next cycle.
  - move_x/move_y are registered and aligned with held.
- Pause: paused toggles in the cycle press[5] is 1. Holding pause does not re-toggle. paused does not gate any other output.
- keycode changes every cycle are legal. No glitch filtering is done; each change is treated as real.

Test Plan:
- Reset sequence: assert reset_n=0 with keycode=16'h0004, then release.
  -> All outputs 0 during reset. First clock after release: held=6'b000010, press=6'b000010, repeat_evt[1]=1, move_x=10.
- Auto-repeat timing: DELAY=3, REPEAT=2. Hold 16'h002C, issue a frame_tick every 10 cycles.
  -> repeat_evt[4] at the press cycle, at tick 3, then at ticks 5, 7, 9.
  -> Releasing between ticks 7 and 9 gives no emit at tick 9 and one release[4] pulse.
- SOCD on X: keycode 16'h0007 -> move_x=01; 16'h0407 -> 10; 16'h0400 -> 10; 16'h0700 -> 01.
  -> Going directly from 16'h0000 to 16'h0407: move_x=00.
- Pause toggle: hold 16'h1300 for 50 cycles, release, then hold again.
  -> paused goes 1 after the first press and stays 1 while held; it goes 0 after the second press. Exactly one press[5] pulse per hold.
- Coincidence: press 16'h001A in the same cycle as frame_tick, DELAY=1.
  -> repeat_evt[0] at the press cycle only; the next emit is at the next frame_tick, not immediately.
- Duplicate code: keycode 16'h1616.
  -> held[2]=1 with a single press pulse. Changing to 16'h0016 produces no release and no second press.
